// File: rtl/codec_cfg_pkg.sv
// WM8731 configuration constants: register map, init words, FSM encoding.
// Words are {reg_addr[6:0], reg_data[8:0]} as sent by the I2C word engine.
package codec_cfg_pkg;

  localparam logic [6:0] ADDR_LLIN   = 7'h00;
  localparam logic [6:0] ADDR_RLIN   = 7'h01;
  localparam logic [6:0] ADDR_LHP    = 7'h02;
  localparam logic [6:0] ADDR_RHP    = 7'h03;
  localparam logic [6:0] ADDR_APATH  = 7'h04;
  localparam logic [6:0] ADDR_DPATH  = 7'h05;
  localparam logic [6:0] ADDR_PWR    = 7'h06;
  localparam logic [6:0] ADDR_IFMT   = 7'h07;
  localparam logic [6:0] ADDR_SRATE  = 7'h08;
  localparam logic [6:0] ADDR_ACTIVE = 7'h09;
  localparam logic [6:0] ADDR_RESET  = 7'h0F;

  localparam logic [15:0] W_RESET  = {ADDR_RESET,  9'h000};
  localparam logic [15:0] W_LLIN   = {ADDR_LLIN,   9'h017};
  localparam logic [15:0] W_RLIN   = {ADDR_RLIN,   9'h017};
  localparam logic [15:0] W_LHP    = {ADDR_LHP,    9'h07F};
  localparam logic [15:0] W_RHP    = {ADDR_RHP,    9'h07F};
  localparam logic [15:0] W_APATH  = {ADDR_APATH,  9'h012};
  localparam logic [15:0] W_DPATH  = {ADDR_DPATH,  9'h000};
  localparam logic [15:0] W_PWR    = {ADDR_PWR,    9'h002};
  localparam logic [15:0] W_IFMT   = {ADDR_IFMT,   9'h023};
  localparam logic [15:0] W_SRATE  = {ADDR_SRATE,  9'h001};
  localparam logic [15:0] W_ACTIVE = {ADDR_ACTIVE, 9'h001};

  localparam logic [3:0] RUNTIME_IDX = 4'hF;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_IDLE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/codec_init_rom.sv
// Combinational init-table lookup, index -> configuration word.
// Codec reset goes first so every field starts from a known value.
module codec_init_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]  index,
  output logic [15:0] word
);

  always_comb begin
    word = 16'h0000;
    case (index)
      4'd0:  word = W_RESET;
      4'd1:  word = W_LLIN;
      4'd2:  word = W_RLIN;
      4'd3:  word = W_LHP;
      4'd4:  word = W_RHP;
      4'd5:  word = W_APATH;
      4'd6:  word = W_DPATH;
      4'd7:  word = W_PWR;
      4'd8:  word = W_IFMT;
      4'd9:  word = W_SRATE;
      4'd10: word = W_ACTIVE;
      default: word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// WM8731 init sequencer over a handshaked I2C word engine, with
// retry, done-timeout, sticky error and a runtime register-write port.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int PWR_WAIT_CYC = 500000,
  parameter int GAP_CYC      = 1000,
  parameter int TIMEOUT_CYC  = 100000,
  parameter int MAX_RETRY    = 3,
  parameter int NUM_REGS     = 11
) (
  input  logic        clk,
  input  logic        reset,
  output logic        i2c_start,
  output logic [15:0] i2c_word,
  input  logic        i2c_done,
  input  logic        i2c_ack_ok,
  input  logic        upd_valid,
  input  logic [15:0] upd_word,
  output logic        upd_ready,
  output logic        cfg_done,
  output logic        stream_en,
  output logic        busy,
  output logic        cfg_error,
  output logic [3:0]  err_index
);

  localparam int M1 =
    (PWR_WAIT_CYC > GAP_CYC) ? PWR_WAIT_CYC : GAP_CYC;
  localparam int CNT_MAX =
    (M1 > TIMEOUT_CYC) ? M1 : TIMEOUT_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] PWR_LD = CW'(PWR_WAIT_CYC - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TO_LD  = CW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [3:0]    END_IDX   = 4'(NUM_REGS);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [3:0]    index_q, index_d;
  logic [15:0]   word_q, word_d;
  logic          rt_q, rt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [3:0]    err_idx_q, err_idx_d;
  logic          busy_q, busy_d;
  logic [15:0]   rom_word;
  logic          fail;

  codec_init_rom u_rom (
    .index (index_q),
    .word  (rom_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_PWR_WAIT;
      cnt_q     <= PWR_LD;
      retry_q   <= '0;
      index_q   <= '0;
      word_q    <= '0;
      rt_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      index_q   <= index_d;
      word_q    <= word_d;
      rt_q      <= rt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      busy_q    <= busy_d;
    end
  end

  // i2c_done takes priority over a timeout landing the same cycle
  assign fail = i2c_done ? !i2c_ack_ok : (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    retry_d   = retry_q;
    index_d   = index_q;
    word_d    = word_q;
    rt_d      = rt_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    unique case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ISSUE;
          word_d  = rom_word;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
        cnt_d   = TO_LD;
      end
      ST_WAIT_DONE: begin
        if (i2c_done && i2c_ack_ok) begin
          retry_d = '0;
          if (!rt_q) index_d = index_q + 4'd1;
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else if (fail) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end else begin
            err_d     = 1'b1;
            err_idx_d = rt_q ? RUNTIME_IDX : index_q;
            state_d   = ST_ERROR;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          // nonzero retry means the held word is reissued
          if (retry_q != '0) begin
            state_d = ST_ISSUE;
          end else if (rt_q) begin
            state_d = ST_IDLE;
            rt_d    = 1'b0;
          end else if (index_q < END_IDX) begin
            state_d = ST_ISSUE;
            word_d  = rom_word;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (upd_valid) begin
          state_d = ST_ISSUE;
          word_d  = upd_word;
          rt_d    = 1'b1;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: state_d = ST_PWR_WAIT;
    endcase
    busy_d = !(state_d == ST_IDLE || state_d == ST_ERROR);
  end

  always_comb begin
    i2c_start = (state_q == ST_ISSUE);
    i2c_word  = word_q;
    upd_ready = (state_q == ST_IDLE);
    cfg_done  = done_q;
    stream_en = done_q;
    busy      = busy_q;
    cfg_error = err_q;
    err_index = err_idx_q;
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer: behavioural I2C responder plus
// a table-driven model of the expected word sequence.
module tb_codec_cfg_sequencer;

  localparam int PWR = 8;
  localparam int GAP = 4;
  localparam int TO  = 20;
  localparam int MR  = 3;
  localparam int NR  = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i2c_start;
  logic [15:0] i2c_word;
  logic        i2c_done = 1'b0;
  logic        i2c_ack_ok = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_word = '0;
  logic        upd_ready, cfg_done, stream_en, busy, cfg_error;
  logic [3:0]  err_index;

  codec_cfg_sequencer #(
    .PWR_WAIT_CYC (PWR),
    .GAP_CYC      (GAP),
    .TIMEOUT_CYC  (TO),
    .MAX_RETRY    (MR),
    .NUM_REGS     (NR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i2c_start  (i2c_start),
    .i2c_word   (i2c_word),
    .i2c_done   (i2c_done),
    .i2c_ack_ok (i2c_ack_ok),
    .upd_valid  (upd_valid),
    .upd_word   (upd_word),
    .upd_ready  (upd_ready),
    .cfg_done   (cfg_done),
    .stream_en  (stream_en),
    .busy       (busy),
    .cfg_error  (cfg_error),
    .err_index  (err_index)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [NR] = '{16'h1E00, 16'h0017, 16'h0217,
    16'h047F, 16'h067F, 16'h0812, 16'h0A00, 16'h0C02,
    16'h0E23, 16'h1001, 16'h1201};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rst_cyc = 0;
  int consec_err = 0;
  int stable_err = 0;
  int acc_cnt = 0;

  logic [15:0] start_q [$];
  int          start_t [$];
  logic [15:0] exp_q [$];

  logic [15:0] nack_word = '0;
  int          nack_left = 0;
  logic        silent_en = 1'b0;
  logic [15:0] silent_word = '0;
  logic        noise_en = 1'b0;

  logic        pend = 1'b0;
  logic        prev_start = 1'b0;
  logic [15:0] cur = '0;
  int          dly = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && upd_valid && upd_ready) acc_cnt <= acc_cnt + 1;
  end

  // responder: one transaction at a time, random latency
  always @(negedge clk) begin
    i2c_done = 1'b0;
    i2c_ack_ok = 1'b0;
    if (reset) begin
      pend = 1'b0;
    end else if (i2c_start) begin
      if (prev_start) consec_err++;
      pend = 1'b1;
      cur = i2c_word;
      dly = $urandom_range(0, 5);
      start_q.push_back(i2c_word);
      start_t.push_back(cyc);
    end else if (pend) begin
      if (i2c_word !== cur) stable_err++;
      if (!(silent_en && cur == silent_word)) begin
        if (dly == 0) begin
          i2c_done = 1'b1;
          pend = 1'b0;
          if (cur == nack_word && nack_left > 0) begin
            nack_left--;
          end else begin
            i2c_ack_ok = 1'b1;
          end
        end else begin
          dly--;
        end
      end
    end else if (noise_en && $urandom_range(0, 3) == 0) begin
      i2c_done = 1'b1;
      i2c_ack_ok = 1'($urandom_range(0, 1));
    end
    prev_start = reset ? 1'b0 : i2c_start;
  end

  task automatic model_init(input logic [15:0] nw, input int nc,
                            input logic sil, input logic [15:0] sw,
                            output int err);
    int f;
    exp_q.delete();
    err = -1;
    for (int i = 0; i < NR; i++) begin
      f = (sil && tbl[i] == sw) ? 1000 : (tbl[i] == nw ? nc : 0);
      for (int a = 0; a <= MR && a <= f; a++) exp_q.push_back(tbl[i]);
      if (f > MR) begin
        err = i;
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    upd_valid = 1'b0;
    repeat (2) @(negedge clk);
    start_q.delete();
    start_t.delete();
    acc_cnt = 0;
    rst_cyc = cyc;
    reset = 1'b0;
  endtask

  task automatic run_init(input logic [15:0] nw, input int nc,
                          input logic sil, input logic [15:0] sw,
                          input logic noise, output logic to);
    nack_word = nw;
    nack_left = nc;
    silent_en = sil;
    silent_word = sw;
    noise_en = noise;
    do_reset();
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cfg_done || cfg_error) begin
        to = 1'b0;
        break;
      end
    end
    repeat (60) @(negedge clk);
    noise_en = 1'b0;
  endtask

  function automatic int seq_bad();
    if (start_q.size() != exp_q.size()) return 1;
    foreach (exp_q[i]) if (start_q[i] !== exp_q[i]) return 1;
    return 0;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({i2c_start, upd_ready, cfg_done, stream_en, busy, cfg_error}
        !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags got=%b want=000000",
        {i2c_start, upd_ready, cfg_done, stream_en, busy, cfg_error});
    end
    tests++;
    if (i2c_word !== 16'h0000 || err_index !== 4'h0) begin
      fails++;
      $display("FAIL reset_word got=%h/%h want=0000/0",
        i2c_word, err_index);
    end
    reset = 1'b0;
  endtask

  task automatic test_all_ack();
    logic to;
    int e;
    int bad;
    model_init(16'h0, 0, 1'b0, 16'h0, e);
    run_init(16'h0, 0, 1'b0, 16'h0, 1'b1, to);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL all_ack_timeout got=timeout want=cfg_done");
    end
    tests++;
    if (seq_bad()) begin
      fails++;
      $display("FAIL all_ack_seq got=%0d words want=%0d",
        start_q.size(), exp_q.size());
    end
    tests++;
    if (start_t.size() == 0 || start_t[0] - rst_cyc != PWR) begin
      fails++;
      $display("FAIL pwr_wait got=%0d want=%0d",
        start_t.size() ? start_t[0] - rst_cyc : -1, PWR);
    end
    bad = 0;
    for (int i = 1; i < start_t.size(); i++)
      if (start_t[i] - start_t[i-1] < GAP) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL gap_spacing got=%0d short want=0", bad);
    end
    tests++;
    if ({cfg_done, stream_en, busy, upd_ready, cfg_error}
        !== 5'b11010) begin
      fails++;
      $display("FAIL all_ack_flags got=%b want=11010",
        {cfg_done, stream_en, busy, upd_ready, cfg_error});
    end
  endtask

  task automatic test_nack_once();
    logic to;
    int e;
    model_init(16'h047F, 1, 1'b0, 16'h0, e);
    run_init(16'h047F, 1, 1'b0, 16'h0, 1'b0, to);
    tests++;
    if (to || seq_bad()) begin
      fails++;
      $display("FAIL nack_once_seq got=%0d words want=%0d",
        start_q.size(), exp_q.size());
    end
    tests++;
    if (cfg_done !== 1'b1 || cfg_error !== 1'b0) begin
      fails++;
      $display("FAIL nack_once_flags got=%b%b want=10",
        cfg_done, cfg_error);
    end
  endtask

  task automatic test_nack_always();
    logic to;
    int e;
    model_init(16'h0812, 1000, 1'b0, 16'h0, e);
    run_init(16'h0812, 1000, 1'b0, 16'h0, 1'b0, to);
    tests++;
    if (to || seq_bad()) begin
      fails++;
      $display("FAIL nack_always_seq got=%0d words want=%0d",
        start_q.size(), exp_q.size());
    end
    tests++;
    if (cfg_error !== 1'b1 || err_index !== 4'(e)) begin
      fails++;
      $display("FAIL nack_always_err got=%b/%0d want=1/%0d",
        cfg_error, err_index, e);
    end
    tests++;
    if ({cfg_done, busy, upd_ready, i2c_start} !== 4'b0) begin
      fails++;
      $display("FAIL error_state got=%b want=0000",
        {cfg_done, busy, upd_ready, i2c_start});
    end
  endtask

  task automatic test_timeout();
    logic to;
    int e;
    int bad;
    model_init(16'h0, 0, 1'b1, 16'h1E00, e);
    run_init(16'h0, 0, 1'b1, 16'h1E00, 1'b0, to);
    silent_en = 1'b0;
    tests++;
    if (to || seq_bad()) begin
      fails++;
      $display("FAIL timeout_seq got=%0d words want=%0d",
        start_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 1; i < start_t.size(); i++)
      if (start_t[i] - start_t[i-1] != 1 + TO + GAP) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL timeout_period got=%0d bad want=0 (period %0d)",
        bad, 1 + TO + GAP);
    end
    tests++;
    if (cfg_error !== 1'b1 || err_index !== 4'h0) begin
      fails++;
      $display("FAIL timeout_err got=%b/%0d want=1/0",
        cfg_error, err_index);
    end
  endtask

  task automatic test_runtime_update();
    logic to;
    int e;
    model_init(16'h0, 0, 1'b0, 16'h0, e);
    run_init(16'h0, 0, 1'b0, 16'h0, 1'b0, to);
    start_q.delete();
    acc_cnt = 0;
    upd_word = 16'h047F;
    upd_valid = 1'b1;
    repeat (4) @(negedge clk);
    upd_valid = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (upd_ready) begin
        to = 1'b0;
        break;
      end
    end
    tests++;
    if (to || acc_cnt != 1) begin
      fails++;
      $display("FAIL upd_accept got=%0d accepts want=1", acc_cnt);
    end
    tests++;
    if (start_q.size() != 1 || start_q[0] !== 16'h047F) begin
      fails++;
      $display("FAIL upd_word got=%0d starts want=1 of 047f",
        start_q.size());
    end
    tests++;
    if ({cfg_done, busy, cfg_error} !== 3'b100) begin
      fails++;
      $display("FAIL upd_idle got=%b want=100",
        {cfg_done, busy, cfg_error});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    int nc;
    int bad;
    logic to;
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      w = 16'($urandom);
      nc = (k == 6) ? 4 : $urandom_range(0, 3);
      nack_word = w;
      nack_left = nc;
      start_q.delete();
      @(negedge clk);
      upd_word = w;
      upd_valid = 1'b1;
      @(negedge clk);
      upd_valid = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (upd_ready || cfg_error) begin
          to = 1'b0;
          break;
        end
      end
      if (to || start_q.size() != (nc > MR ? MR + 1 : nc + 1)) bad++;
      foreach (start_q[i]) if (start_q[i] !== w) bad++;
      if (k < 6 && cfg_error) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL b2b_runtime got=%0d bad want=0", bad);
    end
    tests++;
    if ({cfg_error, cfg_done, stream_en} !== 3'b111 ||
        err_index !== 4'hF) begin
      fails++;
      $display("FAIL runtime_err got=%b/%h want=111/f",
        {cfg_error, cfg_done, stream_en}, err_index);
    end
    start_q.delete();
    upd_word = 16'h1234;
    upd_valid = 1'b1;
    repeat (50) @(negedge clk);
    upd_valid = 1'b0;
    tests++;
    if (start_q.size() != 0 || upd_ready !== 1'b0) begin
      fails++;
      $display("FAIL error_terminal got=%0d starts want=0",
        start_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic to;
    nack_left = 0;
    silent_en = 1'b1;
    silent_word = 16'h0C02;
    do_reset();
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (start_q.size() >= 8) begin
        to = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (to || {i2c_start, busy, cfg_done, upd_ready} !== 4'b0 ||
        i2c_word !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid got=%b/%h want=0000/0000",
        {i2c_start, busy, cfg_done, upd_ready}, i2c_word);
    end
    silent_en = 1'b0;
    start_q.delete();
    start_t.delete();
    rst_cyc = cyc;
    reset = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cfg_done) begin
        to = 1'b0;
        break;
      end
    end
    tests++;
    if (to || start_q.size() != NR || start_q[0] !== 16'h1E00 ||
        start_t[0] - rst_cyc != PWR) begin
      fails++;
      $display("FAIL replay got=%0d words want=%0d from 1e00",
        start_q.size(), NR);
    end
  endtask

  task automatic test_invariants();
    tests++;
    if (consec_err != 0 || stable_err != 0) begin
      fails++;
      $display("FAIL invariants got=%0d/%0d want=0/0",
        consec_err, stable_err);
    end
  endtask

  initial begin
    test_reset();
    test_all_ack();
    test_nack_once();
    test_nack_always();
    test_timeout();
    test_runtime_update();
    test_back_to_back();
    test_reset_mid();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
